// File: rtl/cci_mpf_csr_wr_dispatch.sv
// CSR write dispatcher for MPF.
// Decoded MMIO CSR writes are queued in arrival order and then replayed as
// configuration updates to the VTP, VC MAP and WRO shims. VTP page
// invalidations are followed by a forced idle gap so the VTP shim has time
// to finish each one.
module cci_mpf_csr_wr_dispatch #(
  parameter int FIFO_DEPTH    = 8,
  parameter int INVAL_GAP     = 4,
  parameter int CL_ADDR_WIDTH = 42
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     wr_valid,
  input  logic [3:0]               wr_idx,
  input  logic [63:0]              wr_data,
  output logic                     overflow,
  output logic                     busy,
  output logic [1:0]               vtp_mode,
  output logic [CL_ADDR_WIDTH-1:0] vtp_pt_base,
  output logic                     vtp_pt_base_valid,
  output logic [CL_ADDR_WIDTH-1:0] vtp_inval_page,
  output logic                     vtp_inval_page_valid,
  output logic [63:0]              vc_map_ctrl,
  output logic                     vc_map_ctrl_valid,
  output logic [63:0]              wro_ctrl,
  output logic                     wro_ctrl_valid
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int GW = (INVAL_GAP > 0) ? $clog2(INVAL_GAP + 1) : 1;
  localparam int EW = 4 + 64;

  localparam logic [3:0] IDX_VTP_MODE   = 4'd0;
  localparam logic [3:0] IDX_PT_BASE    = 4'd1;
  localparam logic [3:0] IDX_INVAL_PAGE = 4'd2;
  localparam logic [3:0] IDX_VC_MAP     = 4'd3;
  localparam logic [3:0] IDX_WRO        = 4'd4;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    GAP  = 1'b1
  } state_t;

  // Queue storage and bookkeeping
  logic [EW-1:0] fifo_mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_reg, wr_ptr_next;
  logic [AW-1:0] rd_ptr_reg, rd_ptr_next;
  logic [CW-1:0] count_reg, count_next;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  logic [EW-1:0] head_entry;
  logic [3:0]    head_idx;
  logic [63:0]   head_data;

  // Dispatch FSM and pacing counter
  state_t        state_reg, state_next;
  logic [GW-1:0] gap_cnt_reg, gap_cnt_next;
  logic          overflow_reg, overflow_next;

  // Registered shim-side outputs
  logic [1:0]               vtp_mode_reg, vtp_mode_next;
  logic [CL_ADDR_WIDTH-1:0] pt_base_reg, pt_base_next;
  logic                     pt_base_valid_reg, pt_base_valid_next;
  logic [CL_ADDR_WIDTH-1:0] inval_page_reg, inval_page_next;
  logic                     inval_valid_reg, inval_valid_next;
  logic [63:0]              vc_map_reg, vc_map_next;
  logic                     vc_map_valid_reg, vc_map_valid_next;
  logic [63:0]              wro_reg, wro_next;
  logic                     wro_valid_reg, wro_valid_next;

  // Full/empty come from the registered occupancy, so a pop in the same
  // cycle never rescues a write that arrives while the queue is full.
  assign full       = (count_reg == CW'(FIFO_DEPTH));
  assign empty      = (count_reg == '0);
  assign push       = wr_valid & ~full;
  assign pop        = (state_reg == IDLE) & ~empty;
  assign head_entry = fifo_mem[rd_ptr_reg];
  assign head_idx   = head_entry[EW-1:64];
  assign head_data  = head_entry[63:0];

  // Queue storage write; contents need no reset since occupancy gates use
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_reg] <= {wr_idx, wr_data};
    end
  end

  // Pointer, occupancy and sticky overflow next-state
  always_comb begin
    wr_ptr_next   = wr_ptr_reg;
    rd_ptr_next   = rd_ptr_reg;
    count_next    = count_reg;
    overflow_next = overflow_reg | (wr_valid & full);
    if (push) begin
      wr_ptr_next = wr_ptr_reg + AW'(1);
    end
    if (pop) begin
      rd_ptr_next = rd_ptr_reg + AW'(1);
    end
    case ({push, pop})
      2'b10:   count_next = count_reg + CW'(1);
      2'b01:   count_next = count_reg - CW'(1);
      default: count_next = count_reg;
    endcase
  end

  // Dispatch FSM: decode the popped entry into next output values
  always_comb begin
    state_next         = state_reg;
    gap_cnt_next       = gap_cnt_reg;
    vtp_mode_next      = vtp_mode_reg;
    pt_base_next       = pt_base_reg;
    pt_base_valid_next = 1'b0;
    inval_page_next    = inval_page_reg;
    inval_valid_next   = 1'b0;
    vc_map_next        = vc_map_reg;
    vc_map_valid_next  = 1'b0;
    wro_next           = wro_reg;
    wro_valid_next     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (pop) begin
          case (head_idx)
            IDX_VTP_MODE: begin
              vtp_mode_next = head_data[1:0];
            end
            IDX_PT_BASE: begin
              pt_base_next       = head_data[CL_ADDR_WIDTH-1:0];
              pt_base_valid_next = 1'b1;
            end
            IDX_INVAL_PAGE: begin
              inval_page_next  = head_data[CL_ADDR_WIDTH-1:0];
              inval_valid_next = 1'b1;
              gap_cnt_next     = GW'(INVAL_GAP);
              if (INVAL_GAP > 0) begin
                state_next = GAP;
              end
            end
            IDX_VC_MAP: begin
              vc_map_next       = head_data;
              vc_map_valid_next = 1'b1;
            end
            IDX_WRO: begin
              wro_next       = head_data;
              wro_valid_next = 1'b1;
            end
            default: begin
              // Unused indices are simply dropped from the queue.
            end
          endcase
        end
      end
      GAP: begin
        if (gap_cnt_reg <= GW'(1)) begin
          gap_cnt_next = '0;
          state_next   = IDLE;
        end else begin
          gap_cnt_next = gap_cnt_reg - GW'(1);
        end
      end
      default: begin
        state_next   = IDLE;
        gap_cnt_next = '0;
      end
    endcase
  end

  // State, queue bookkeeping and output registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_reg        <= '0;
      rd_ptr_reg        <= '0;
      count_reg         <= '0;
      overflow_reg      <= 1'b0;
      state_reg         <= IDLE;
      gap_cnt_reg       <= '0;
      vtp_mode_reg      <= '0;
      pt_base_reg       <= '0;
      pt_base_valid_reg <= 1'b0;
      inval_page_reg    <= '0;
      inval_valid_reg   <= 1'b0;
      vc_map_reg        <= '0;
      vc_map_valid_reg  <= 1'b0;
      wro_reg           <= '0;
      wro_valid_reg     <= 1'b0;
    end else begin
      wr_ptr_reg        <= wr_ptr_next;
      rd_ptr_reg        <= rd_ptr_next;
      count_reg         <= count_next;
      overflow_reg      <= overflow_next;
      state_reg         <= state_next;
      gap_cnt_reg       <= gap_cnt_next;
      vtp_mode_reg      <= vtp_mode_next;
      pt_base_reg       <= pt_base_next;
      pt_base_valid_reg <= pt_base_valid_next;
      inval_page_reg    <= inval_page_next;
      inval_valid_reg   <= inval_valid_next;
      vc_map_reg        <= vc_map_next;
      vc_map_valid_reg  <= vc_map_valid_next;
      wro_reg           <= wro_next;
      wro_valid_reg     <= wro_valid_next;
    end
  end

  assign overflow             = overflow_reg;
  assign busy                 = (count_reg != '0) | (state_reg == GAP);
  assign vtp_mode             = vtp_mode_reg;
  assign vtp_pt_base          = pt_base_reg;
  assign vtp_pt_base_valid    = pt_base_valid_reg;
  assign vtp_inval_page       = inval_page_reg;
  assign vtp_inval_page_valid = inval_valid_reg;
  assign vc_map_ctrl          = vc_map_reg;
  assign vc_map_ctrl_valid    = vc_map_valid_reg;
  assign wro_ctrl             = wro_reg;
  assign wro_ctrl_valid       = wro_valid_reg;

endmodule

// File: tb/tb_cci_mpf_csr_wr_dispatch.sv
// Directed bench for the MPF CSR write dispatcher.
// A negedge monitor logs every valid pulse with its cycle number; each test
// task drives writes and compares the log and levels against hand-derived
// expectations.
module tb_cci_mpf_csr_wr_dispatch;

  localparam int CLW = 42;

  logic           clk = 1'b0;
  logic           reset_n = 1'b0;
  logic           wr_valid = 1'b0;
  logic [3:0]     wr_idx = '0;
  logic [63:0]    wr_data = '0;
  logic           overflow;
  logic           busy;
  logic [1:0]     vtp_mode;
  logic [CLW-1:0] vtp_pt_base;
  logic           vtp_pt_base_valid;
  logic [CLW-1:0] vtp_inval_page;
  logic           vtp_inval_page_valid;
  logic [63:0]    vc_map_ctrl;
  logic           vc_map_ctrl_valid;
  logic [63:0]    wro_ctrl;
  logic           wro_ctrl_valid;

  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;
  int multi_cnt = 0;

  // kind: 0 pt_base, 1 inval, 2 vc_map, 3 wro
  typedef struct {
    int          cyc;
    int          kind;
    logic [63:0] data;
  } ev_t;
  ev_t evq[$];

  cci_mpf_csr_wr_dispatch #(
    .FIFO_DEPTH    (8),
    .INVAL_GAP     (4),
    .CL_ADDR_WIDTH (CLW)
  ) dut (
    .clk                  (clk),
    .reset_n              (reset_n),
    .wr_valid             (wr_valid),
    .wr_idx               (wr_idx),
    .wr_data              (wr_data),
    .overflow             (overflow),
    .busy                 (busy),
    .vtp_mode             (vtp_mode),
    .vtp_pt_base          (vtp_pt_base),
    .vtp_pt_base_valid    (vtp_pt_base_valid),
    .vtp_inval_page       (vtp_inval_page),
    .vtp_inval_page_valid (vtp_inval_page_valid),
    .vc_map_ctrl          (vc_map_ctrl),
    .vc_map_ctrl_valid    (vc_map_ctrl_valid),
    .wro_ctrl             (wro_ctrl),
    .wro_ctrl_valid       (wro_ctrl_valid)
  );

  // Free-running clock
  always #5 clk = ~clk;

  // Cycle counter, advanced on each active edge
  always @(posedge clk) cyc <= cyc + 1;

  // Pulse monitor sampled mid-cycle
  always @(negedge clk) begin
    if ($countones({vtp_pt_base_valid, vtp_inval_page_valid,
                    vc_map_ctrl_valid, wro_ctrl_valid}) > 1)
      multi_cnt <= multi_cnt + 1;
    if (vtp_pt_base_valid)    evq.push_back(ev_t'{cyc, 0, 64'(vtp_pt_base)});
    if (vtp_inval_page_valid) evq.push_back(ev_t'{cyc, 1, 64'(vtp_inval_page)});
    if (vc_map_ctrl_valid)    evq.push_back(ev_t'{cyc, 2, vc_map_ctrl});
    if (wro_ctrl_valid)       evq.push_back(ev_t'{cyc, 3, wro_ctrl});
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input logic [3:0] i, input logic [63:0] d);
    wr_valid = 1'b1;
    wr_idx   = i;
    wr_data  = d;
    step(1);
    wr_valid = 1'b0;
    wr_idx   = '0;
    wr_data  = '0;
  endtask

  task automatic wait_quiet(input string name, input int limit);
    int k;
    k = 0;
    while (busy !== 1'b0 && k < limit) begin
      step(1);
      k++;
    end
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_drain: busy=%0b after %0d cycles, required 0", name, busy, limit);
    end
    step(2);
  endtask

  task automatic test_reset();
    int n;
    step(3);
    @(negedge clk);
    n_checks++;
    if (overflow !== 1'b0) begin n_fail++; $display("FAIL rst_overflow: got %0b required 0", overflow); end
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %0b required 0", busy); end
    n_checks++;
    if (vtp_mode !== 2'd0) begin n_fail++; $display("FAIL rst_vtp_mode: got %0h required 0", vtp_mode); end
    n_checks++;
    if (vtp_pt_base !== '0) begin n_fail++; $display("FAIL rst_pt_base: got %0h required 0", vtp_pt_base); end
    n_checks++;
    if (vtp_inval_page !== '0) begin n_fail++; $display("FAIL rst_inval_page: got %0h required 0", vtp_inval_page); end
    n_checks++;
    if (vc_map_ctrl !== 64'd0) begin n_fail++; $display("FAIL rst_vc_map: got %0h required 0", vc_map_ctrl); end
    n_checks++;
    if (wro_ctrl !== 64'd0) begin n_fail++; $display("FAIL rst_wro: got %0h required 0", wro_ctrl); end
    n_checks++;
    if ({vtp_pt_base_valid, vtp_inval_page_valid, vc_map_ctrl_valid, wro_ctrl_valid} !== 4'b0000) begin
      n_fail++;
      $display("FAIL rst_valids: got %b required 0000",
               {vtp_pt_base_valid, vtp_inval_page_valid, vc_map_ctrl_valid, wro_ctrl_valid});
    end
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    step(1);
    evq.delete();
    n = cyc;
    wr(4'd1, 64'h1234);
    step(4);
    n_checks++;
    if (evq.size() !== 1) begin
      n_fail++;
      $display("FAIL first_pt_base_count: got %0d pulses required 1", evq.size());
    end
    if (evq.size() > 0) begin
      n_checks++;
      if (evq[0].kind !== 0 || evq[0].data !== 64'h1234 || evq[0].cyc !== n + 2) begin
        n_fail++;
        $display("FAIL first_pt_base: got kind %0d data %0h cyc %0d required kind 0 data 1234 cyc %0d",
                 evq[0].kind, evq[0].data, evq[0].cyc, n + 2);
      end
    end
    n_checks++;
    if (vtp_pt_base !== 42'h1234) begin n_fail++; $display("FAIL pt_base_hold: got %0h required 1234", vtp_pt_base); end
    $display("test_reset: %0d pulses logged", evq.size());
  endtask

  task automatic test_burst();
    int n;
    int ec[2];
    int ek[2];
    logic [63:0] ed[2];
    evq.delete();
    n = cyc;
    wr(4'd3, 64'hA);
    wr(4'd4, 64'hB);
    wr(4'd0, 64'h3);
    @(negedge clk);
    n_checks++;
    if (vtp_mode !== 2'd0) begin n_fail++; $display("FAIL burst_mode_early: got %0d required 0", vtp_mode); end
    @(negedge clk);
    n_checks++;
    if (vtp_mode !== 2'd3) begin n_fail++; $display("FAIL burst_mode: got %0d required 3", vtp_mode); end
    @(posedge clk);
    #1;
    wait_quiet("burst", 20);
    ec[0] = n + 2; ek[0] = 2; ed[0] = 64'hA;
    ec[1] = n + 3; ek[1] = 3; ed[1] = 64'hB;
    n_checks++;
    if (evq.size() !== 2) begin n_fail++; $display("FAIL burst_count: got %0d pulses required 2", evq.size()); end
    for (int k = 0; k < 2; k++) begin
      if (k < evq.size()) begin
        n_checks++;
        if (evq[k].kind !== ek[k] || evq[k].data !== ed[k] || evq[k].cyc !== ec[k]) begin
          n_fail++;
          $display("FAIL burst_ev%0d: got kind %0d data %0h cyc %0d required kind %0d data %0h cyc %0d",
                   k, evq[k].kind, evq[k].data, evq[k].cyc, ek[k], ed[k], ec[k]);
        end
      end
    end
    n_checks++;
    if (vc_map_ctrl !== 64'hA || wro_ctrl !== 64'hB) begin
      n_fail++;
      $display("FAIL burst_levels: got vc %0h wro %0h required A B", vc_map_ctrl, wro_ctrl);
    end
    $display("test_burst: %0d pulses logged", evq.size());
  endtask

  task automatic test_pacing();
    int n;
    int ec[3];
    int ek[3];
    logic [63:0] ed[3];
    evq.delete();
    n = cyc;
    wr(4'd2, 64'h100);
    wr(4'd2, 64'h200);
    wr(4'd3, 64'h5);
    n_checks++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL pacing_busy: got %0b required 1", busy); end
    wait_quiet("pacing", 40);
    ec[0] = n + 2;  ek[0] = 1; ed[0] = 64'h100;
    ec[1] = n + 7;  ek[1] = 1; ed[1] = 64'h200;
    ec[2] = n + 12; ek[2] = 2; ed[2] = 64'h5;
    n_checks++;
    if (evq.size() !== 3) begin n_fail++; $display("FAIL pacing_count: got %0d pulses required 3", evq.size()); end
    for (int k = 0; k < 3; k++) begin
      if (k < evq.size()) begin
        n_checks++;
        if (evq[k].kind !== ek[k] || evq[k].data !== ed[k] || evq[k].cyc !== ec[k]) begin
          n_fail++;
          $display("FAIL pacing_ev%0d: got kind %0d data %0h cyc %0d required kind %0d data %0h cyc %0d",
                   k, evq[k].kind, evq[k].data, evq[k].cyc, ek[k], ed[k], ec[k]);
        end
      end
    end
    n_checks++;
    if (vtp_inval_page !== 42'h200) begin n_fail++; $display("FAIL pacing_level: got %0h required 200", vtp_inval_page); end
    $display("test_pacing: %0d pulses logged", evq.size());
  endtask

  // Eleven back-to-back invalidations: gaps throttle pops to one per five
  // cycles, so the queue reaches 8 entries at the eleventh write, which drops.
  task automatic test_overflow();
    int n;
    evq.delete();
    n = cyc;
    for (int i = 0; i < 11; i++) begin
      if (i == 10) begin
        n_checks++;
        if (overflow !== 1'b0) begin n_fail++; $display("FAIL overflow_early: got %0b required 0", overflow); end
      end
      wr(4'd2, 64'(i));
    end
    n_checks++;
    if (overflow !== 1'b1) begin n_fail++; $display("FAIL overflow_set: got %0b required 1", overflow); end
    wait_quiet("overflow", 100);
    n_checks++;
    if (evq.size() !== 10) begin n_fail++; $display("FAIL overflow_count: got %0d pulses required 10", evq.size()); end
    for (int k = 0; k < 10; k++) begin
      if (k < evq.size()) begin
        n_checks++;
        if (evq[k].kind !== 1 || evq[k].data !== 64'(k) || evq[k].cyc !== n + 2 + 5 * k) begin
          n_fail++;
          $display("FAIL overflow_ev%0d: got kind %0d data %0h cyc %0d required kind 1 data %0h cyc %0d",
                   k, evq[k].kind, evq[k].data, evq[k].cyc, k, n + 2 + 5 * k);
        end
      end
    end
    n_checks++;
    if (overflow !== 1'b1) begin n_fail++; $display("FAIL overflow_sticky: got %0b required 1", overflow); end
    $display("test_overflow: %0d pulses logged, overflow=%0b", evq.size(), overflow);
  endtask

  task automatic test_ignored();
    int n;
    evq.delete();
    n = cyc;
    wr(4'd7, 64'hFF);
    wr(4'd4, 64'h9);
    wait_quiet("ignored", 20);
    n_checks++;
    if (evq.size() !== 1) begin n_fail++; $display("FAIL ignored_count: got %0d pulses required 1", evq.size()); end
    if (evq.size() > 0) begin
      n_checks++;
      if (evq[0].kind !== 3 || evq[0].data !== 64'h9 || evq[0].cyc !== n + 3) begin
        n_fail++;
        $display("FAIL ignored_wro: got kind %0d data %0h cyc %0d required kind 3 data 9 cyc %0d",
                 evq[0].kind, evq[0].data, evq[0].cyc, n + 3);
      end
    end
    n_checks++;
    if (wro_ctrl !== 64'h9) begin n_fail++; $display("FAIL ignored_level: got %0h required 9", wro_ctrl); end
    n_checks++;
    if (overflow !== 1'b1) begin n_fail++; $display("FAIL overflow_still_set: got %0b required 1", overflow); end
    $display("test_ignored: %0d pulses logged", evq.size());
  endtask

  task automatic test_reset_mid_gap();
    int n;
    evq.delete();
    n = cyc;
    wr(4'd2, 64'h300);
    wr(4'd3, 64'h1);
    wr(4'd4, 64'h2);
    wr(4'd1, 64'h3);
    n_checks++;
    if (busy !== 1'b1 || evq.size() !== 1) begin
      n_fail++;
      $display("FAIL midgap_pre: got busy %0b pulses %0d required busy 1 pulses 1", busy, evq.size());
    end
    reset_n = 1'b0;
    evq.delete();
    step(2);
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL midgap_busy: got %0b required 0", busy); end
    n_checks++;
    if (overflow !== 1'b0) begin n_fail++; $display("FAIL midgap_overflow: got %0b required 0", overflow); end
    n_checks++;
    if (vtp_inval_page !== '0 || wro_ctrl !== 64'd0) begin
      n_fail++;
      $display("FAIL midgap_levels: got inval %0h wro %0h required 0 0", vtp_inval_page, wro_ctrl);
    end
    reset_n = 1'b1;
    step(10);
    n_checks++;
    if (evq.size() !== 0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL midgap_after: got pulses %0d busy %0b required 0 0", evq.size(), busy);
    end
    n = cyc;
    wr(4'd3, 64'h77);
    step(4);
    n_checks++;
    if (evq.size() !== 1) begin n_fail++; $display("FAIL midgap_fresh_count: got %0d pulses required 1", evq.size()); end
    if (evq.size() > 0) begin
      n_checks++;
      if (evq[0].kind !== 2 || evq[0].data !== 64'h77 || evq[0].cyc !== n + 2) begin
        n_fail++;
        $display("FAIL midgap_fresh: got kind %0d data %0h cyc %0d required kind 2 data 77 cyc %0d",
                 evq[0].kind, evq[0].data, evq[0].cyc, n + 2);
      end
    end
    $display("test_reset_mid_gap: %0d pulses after release", evq.size());
  endtask

  task automatic test_one_pulse();
    n_checks++;
    if (multi_cnt !== 0) begin n_fail++; $display("FAIL one_pulse: got %0d multi-pulse cycles required 0", multi_cnt); end
    $display("test_one_pulse: %0d multi-pulse cycles", multi_cnt);
  endtask

  initial begin
    test_reset();
    test_burst();
    test_pacing();
    test_overflow();
    test_ignored();
    test_reset_mid_gap();
    test_one_pulse();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
